// File: rtl/touch_key_filter_pkg.sv
// touch_key_filter_pkg: shared state encoding and timing constants for the touch-key path.
package touch_key_filter_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    localparam int DEB_W  = 20;
    localparam int LONG_W = 25;
    localparam int DTAP_W = 24;

    // 50 MHz defaults: 20 ms debounce, 500 ms long press, 300 ms double-tap window
    localparam logic [DEB_W-1:0]  DEB_CNT_MAX_DEF  = 20'd999_999;
    localparam logic [LONG_W-1:0] LONG_CNT_MAX_DEF = 25'd24_999_999;
    localparam logic [DTAP_W-1:0] DTAP_CNT_MAX_DEF = 24'd14_999_999;

    localparam logic [DEB_W-1:0]  DEB_CNT_MAX_SIM  = 20'd9;
    localparam logic [LONG_W-1:0] LONG_CNT_MAX_SIM = 25'd99;
    localparam logic [DTAP_W-1:0] DTAP_CNT_MAX_SIM = 24'd49;

endpackage

// File: rtl/touch_key_filter_sync_2ff.sv
// touch_key_filter_sync_2ff: two-flop synchroniser for an asynchronous pin, reset to RST_VAL.
module touch_key_filter_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], d};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= {2{RST_VAL}};
        else        sync_q <= sync_d;

    assign q = sync_q[1];

endmodule

// File: rtl/touch_key_filter.sv
// touch_key_filter: synchronises and debounces the touch pin, emitting press, release,
// long-press and double-tap single-cycle pulses.
module touch_key_filter
    import touch_key_filter_pkg::*;
#(
    parameter logic              ACTIVE_LEVEL = 1'b0,
    parameter logic [DEB_W-1:0]  DEB_CNT_MAX  = DEB_CNT_MAX_DEF,
    parameter logic [LONG_W-1:0] LONG_CNT_MAX = LONG_CNT_MAX_DEF,
    parameter logic [DTAP_W-1:0] DTAP_CNT_MAX = DTAP_CNT_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic touch_key,
    output logic key_state,
    output logic key_flag,
    output logic key_release,
    output logic long_press,
    output logic double_tap
);

    logic key_s, act;
    state_t state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic [DTAP_W-1:0] dtap_cnt_q, dtap_cnt_d;
    logic long_fired_q, long_fired_d, dtap_arm_q, dtap_arm_d, dtap_used_q, dtap_used_d;
    logic key_state_q, key_state_d, key_flag_q, key_flag_d, key_release_q, key_release_d;
    logic long_press_q, long_press_d, double_tap_q, double_tap_d;

    touch_key_filter_sync_2ff #(.RST_VAL(~ACTIVE_LEVEL)) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (touch_key),
        .q     (key_s)
    );

    assign act = (key_s == ACTIVE_LEVEL);

    // deb_cnt indexes stable cycles; the detection cycle in IDLE/HELD is index 0
    always_comb begin
        state_d       = state_q;
        deb_cnt_d     = deb_cnt_q;
        long_cnt_d    = long_cnt_q;
        dtap_cnt_d    = dtap_cnt_q;
        long_fired_d  = long_fired_q;
        dtap_arm_d    = dtap_arm_q;
        dtap_used_d   = dtap_used_q;
        key_state_d   = key_state_q;
        key_flag_d    = 1'b0;
        key_release_d = 1'b0;
        long_press_d  = 1'b0;
        double_tap_d  = 1'b0;
        if (dtap_arm_q) begin
            dtap_cnt_d = (dtap_cnt_q == DTAP_CNT_MAX) ? dtap_cnt_q : dtap_cnt_q + 1'b1;
            dtap_arm_d = (dtap_cnt_q != DTAP_CNT_MAX);
        end
        if (state_q == HELD || state_q == REL_DB)
            long_cnt_d = (long_cnt_q == LONG_CNT_MAX) ? long_cnt_q : long_cnt_q + 1'b1;
        case (state_q)
            IDLE: if (act) begin
                state_d   = PRESS_DB;
                deb_cnt_d = DEB_W'(1);
            end
            PRESS_DB: if (!act) state_d = IDLE;
            else if (deb_cnt_q >= DEB_CNT_MAX) begin
                state_d      = HELD;
                key_flag_d   = 1'b1;
                key_state_d  = 1'b1;
                long_cnt_d   = '0;
                long_fired_d = 1'b0;
                double_tap_d = dtap_arm_q;
                dtap_used_d  = dtap_arm_q;
                dtap_arm_d   = 1'b0;
            end else deb_cnt_d = deb_cnt_q + 1'b1;
            HELD: begin
                if (long_cnt_q == LONG_CNT_MAX && !long_fired_q) begin
                    long_press_d = 1'b1;
                    long_fired_d = 1'b1;
                    dtap_arm_d   = 1'b0;
                end
                if (!act) begin
                    state_d   = REL_DB;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            REL_DB: if (act) state_d = HELD;
            else if (deb_cnt_q >= DEB_CNT_MAX) begin
                state_d       = IDLE;
                key_release_d = 1'b1;
                key_state_d   = 1'b0;
                // the release that ends a completed pair must not open a new window
                dtap_arm_d    = !dtap_arm_q && !dtap_used_q && !long_fired_q;
                dtap_used_d   = 1'b0;
                dtap_cnt_d    = '0;
            end else deb_cnt_d = deb_cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            deb_cnt_q     <= '0;
            long_cnt_q    <= '0;
            dtap_cnt_q    <= '0;
            long_fired_q  <= 1'b0;
            dtap_arm_q    <= 1'b0;
            dtap_used_q   <= 1'b0;
            key_state_q   <= 1'b0;
            key_flag_q    <= 1'b0;
            key_release_q <= 1'b0;
            long_press_q  <= 1'b0;
            double_tap_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            long_cnt_q    <= long_cnt_d;
            dtap_cnt_q    <= dtap_cnt_d;
            long_fired_q  <= long_fired_d;
            dtap_arm_q    <= dtap_arm_d;
            dtap_used_q   <= dtap_used_d;
            key_state_q   <= key_state_d;
            key_flag_q    <= key_flag_d;
            key_release_q <= key_release_d;
            long_press_q  <= long_press_d;
            double_tap_q  <= double_tap_d;
        end

    assign key_state   = key_state_q;
    assign key_flag    = key_flag_q;
    assign key_release = key_release_q;
    assign long_press  = long_press_q;
    assign double_tap  = double_tap_q;

endmodule

// File: tb/tb_touch_key_filter.sv
// tb_touch_key_filter: directed stimulus for touch_key_filter, checked every cycle against an
// event-level model (run-length debounce, edge-stamped press/release) plus literal latencies.
module tb_touch_key_filter;
    import touch_key_filter_pkg::*;

    localparam logic ACT = 1'b0;
    localparam int N = int'(DEB_CNT_MAX_SIM);
    localparam int L = int'(LONG_CNT_MAX_SIM);
    localparam int D = int'(DTAP_CNT_MAX_SIM);

    logic sys_clk = 1'b0, sys_rst_n = 1'b1, touch_key = 1'b1;
    logic key_state, key_flag, key_release, long_press, double_tap;

    always #10 sys_clk = ~sys_clk;

    touch_key_filter #(
        .ACTIVE_LEVEL (ACT),
        .DEB_CNT_MAX  (DEB_CNT_MAX_SIM),
        .LONG_CNT_MAX (LONG_CNT_MAX_SIM),
        .DTAP_CNT_MAX (DTAP_CNT_MAX_SIM)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .touch_key   (touch_key),
        .key_state   (key_state),
        .key_flag    (key_flag),
        .key_release (key_release),
        .long_press  (long_press),
        .double_tap  (double_tap)
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input int a, input int e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    // Model: a level change is accepted once the synchronised pin has disagreed with the
    // debounced level for N+1 consecutive cycles; events are stamped with their edge number.
    int  t, run, press_t, rel_t;
    bit  level, fired, armed, used, p1, p2, v, held_prev, arm_eff;
    bit  e_flag, e_rel, e_long, e_dtap;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            t = 0; run = 0; press_t = 0; rel_t = 0;
            level = 0; fired = 0; armed = 0; used = 0;
            p1 = ~ACT; p2 = ~ACT;
            e_flag = 0; e_rel = 0; e_long = 0; e_dtap = 0;
        end else begin
            t++;
            v = (p2 == ACT);
            p2 = p1;
            p1 = touch_key;
            held_prev = level && run == 0;
            arm_eff = armed && (t - rel_t <= D + 1);
            e_flag = 0; e_rel = 0; e_long = 0; e_dtap = 0;
            if (held_prev && !fired && t - press_t >= L + 1) begin
                e_long = 1; fired = 1; armed = 0; arm_eff = 0;
            end
            run = (v != level) ? run + 1 : 0;
            if (run == N + 1) begin
                level = v;
                run = 0;
                if (v) begin
                    e_flag = 1; press_t = t; fired = 0;
                    e_dtap = arm_eff; used = arm_eff; armed = 0;
                end else begin
                    e_rel = 1;
                    armed = !arm_eff && !used && !fired;
                    rel_t = t; used = 0;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        chk("key_state", int'(key_state), int'(level));
        chk("key_flag", int'(key_flag), int'(e_flag));
        chk("key_release", int'(key_release), int'(e_rel));
        chk("long_press", int'(long_press), int'(e_long));
        chk("double_tap", int'(double_tap), int'(e_dtap));
    end

    int c_flag = 0, c_rel = 0, c_long = 0, c_dtap = 0;
    always @(negedge sys_clk) begin
        c_flag += int'(key_flag);
        c_rel  += int'(key_release);
        c_long += int'(long_press);
        c_dtap += int'(double_tap);
    end

    function automatic logic sel(input int which);
        return (which == 0) ? key_flag : (which == 1) ? key_release : long_press;
    endfunction

    // k = number of rising edges until the pulse is seen, -1 if the budget runs out
    task automatic wait_pulse(input int which, input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge sys_clk);
            #1;
            if (sel(which)) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic tap(input int low, input int high);
        touch_key = 1'b0;
        repeat (low) @(negedge sys_clk);
        touch_key = 1'b1;
        repeat (high) @(negedge sys_clk);
    endtask

    function automatic int outs();
        return int'({key_state, key_flag, key_release, long_press, double_tap});
    endfunction

    int k, s0, s1, s2;

    initial begin
        #1 sys_rst_n = 1'b0;
        #99 chk("reset outputs", outs(), 0);
        #101 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        s0 = c_flag + c_rel + c_long + c_dtap;
        repeat (50) @(negedge sys_clk);
        chk("idle pulses", c_flag + c_rel + c_long + c_dtap - s0, 0);
        chk("idle key_state", int'(key_state), 0);

        s0 = c_long;
        touch_key = 1'b0;
        wait_pulse(0, 40, k);
        chk("press latency", k, N + 3);
        chk("press key_state", int'(key_state), 1);
        @(negedge sys_clk);
        repeat (28) @(negedge sys_clk);
        touch_key = 1'b1;
        wait_pulse(1, 40, k);
        chk("release latency", k, N + 3);
        chk("release key_state", int'(key_state), 0);
        chk("short press long", c_long - s0, 0);
        @(negedge sys_clk);
        repeat (60) @(negedge sys_clk);

        s0 = c_flag + c_rel + c_long + c_dtap;
        tap(3, 20);
        tap(5, 20);
        tap(9, 20);
        chk("glitch pulses", c_flag + c_rel + c_long + c_dtap - s0, 0);
        chk("glitch key_state", int'(key_state), 0);

        s0 = c_long; s1 = c_dtap; s2 = c_flag;
        touch_key = 1'b0;
        wait_pulse(0, 40, k);
        chk("long press flag latency", k, N + 3);
        wait_pulse(2, 200, k);
        chk("long press latency", k, L + 1);
        @(negedge sys_clk);
        repeat (37) @(negedge sys_clk);
        touch_key = 1'b1;
        wait_pulse(1, 40, k);
        chk("long release latency", k, N + 3);
        @(negedge sys_clk);
        repeat (20) @(negedge sys_clk);
        tap(20, 60);
        chk("long press count", c_long - s0, 1);
        chk("tap after long dtap", c_dtap - s1, 0);
        chk("tap after long flags", c_flag - s2, 2);
        repeat (60) @(negedge sys_clk);

        s1 = c_dtap; s2 = c_flag;
        tap(20, 30);
        tap(20, 80);
        chk("double tap count", c_dtap - s1, 1);
        chk("double tap flags", c_flag - s2, 2);
        s1 = c_dtap;
        tap(20, 70);
        tap(20, 80);
        chk("slow pair dtap", c_dtap - s1, 0);

        touch_key = 1'b0;
        wait_pulse(0, 40, k);
        chk("held flag latency", k, N + 3);
        @(negedge sys_clk);
        repeat (20) @(negedge sys_clk);
        chk("held key_state", int'(key_state), 1);
        touch_key = 1'b1;
        #3 sys_rst_n = 1'b0;
        #1 chk("held reset outputs", outs(), 0);
        repeat (3) @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        s0 = c_rel;
        repeat (30) @(negedge sys_clk);
        chk("held reset release", c_rel - s0, 0);

        touch_key = 1'b0;
        wait_pulse(0, 40, k);
        chk("reldb flag latency", k, N + 3);
        @(negedge sys_clk);
        repeat (10) @(negedge sys_clk);
        touch_key = 1'b1;
        repeat (5) @(negedge sys_clk);
        chk("reldb key_state", int'(key_state), 1);
        #3 sys_rst_n = 1'b0;
        #1 chk("reldb reset outputs", outs(), 0);
        repeat (3) @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        s0 = c_rel;
        repeat (30) @(negedge sys_clk);
        chk("reldb reset release", c_rel - s0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
